// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
//
// Shared types and helpers for the intersection controller.
//
// Contents:
//   phase_e        - controller phase encoding {GREEN, YELLOW, ALLRED, WALK}.
//                    WALK keeps its code even when pedestrian support is not
//                    built, so the encoding never shifts between builds.
//   DEF_*          - default parameter values for the controller.
//   MAX_DIR        - largest supported number of approaches.
//   rr_next_dir()  - round-robin search for the next requesting approach.
// ---------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        ALLRED = 2'd2,
        WALK   = 2'd3
    } phase_e;

    localparam int DEF_N_DIR    = 2;
    localparam int DEF_CNT_W    = 8;
    localparam int DEF_T_GREEN  = 20;
    localparam int DEF_T_YELLOW = 4;
    localparam int DEF_T_ALLRED = 2;
    localparam int DEF_T_WALK   = 10;

    localparam int MAX_DIR = 8;

    // Returns the first approach after 'active' (wrapping n_dir-1 -> 0) whose
    // request bit is set, or -1 when no other approach is requesting. The
    // active approach itself is never a candidate, so its own request is
    // ignored. The loop has a fixed trip count so it unrolls into a small
    // priority chain in hardware.
    function automatic int rr_next_dir(input logic [MAX_DIR-1:0] req,
                                       input int                 active,
                                       input int                 n_dir);
        int result;
        int idx;
        result = -1;
        for (int k = 1; k < MAX_DIR; k++) begin
            idx = active + k;
            if (idx >= n_dir) begin
                idx = idx - n_dir;
            end
            if ((k < n_dir) && (result < 0) && req[idx[2:0]]) begin
                result = idx;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/traffic_intersection_ctrl_phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer
//
// Saturating tick counter that measures how long the controller has been in
// its current phase.
//
// Ports:
//   clock    in   rising-edge system clock
//   rst      in   asynchronous reset, active-low
//   tick     in   one-clock phase-time strobe; the count only moves on it
//   clear    in   restart the count from zero (phase entry)
//   limit    in   phase duration in ticks (>= 1)
//   expired  out  high on the tick where the count equals limit-1
//
// The count stops at limit-1 instead of wrapping, so a phase that is held
// past its minimum (e.g. a green with no competing demand) reports expired
// on every following tick.
// ---------------------------------------------------------------------------
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             tick,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] last;

    assign last    = limit - CNT_W'(1);
    assign expired = tick && (count_q == last);

    // clear wins over tick: the entry tick of a new phase leaves the count
    // at zero, so the new phase then lasts exactly 'limit' further ticks.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick && (count_q != last)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// ---------------------------------------------------------------------------
// traffic_intersection_ctrl
//
// N-approach intersection controller. One approach is green at a time; the
// green is held until some other approach requests service, then the
// controller runs yellow and an all-red clearance before handing the green to
// the next requesting approach in round-robin order. Everything advances
// only on the 'tick' strobe coming from the clock divider.
//
// Optional feature (macro PED_WALK_EN):
//   Adds ped_req/walk ports. A pedestrian press is remembered in a sticky
//   flag; when the flag is set at the end of an all-red clearance the
//   controller inserts a WALK phase (all red, walk lamp on) before the next
//   green. Without the macro the ports, the flag and the WALK behaviour are
//   absent.
//
// Ports:
//   clock       in   system clock, rising edge
//   rst         in   asynchronous reset, active-low
//   tick        in   phase-time strobe, one clock wide
//   req         in   [N_DIR]  vehicle demand per approach, level
//   green       out  [N_DIR]  green lamp per approach   (registered)
//   yellow      out  [N_DIR]  yellow lamp per approach  (registered)
//   red         out  [N_DIR]  red lamp per approach     (registered)
//   active_dir  out  approach currently owning the phase (registered)
//   ped_req     in   pedestrian button, pulse or level  (PED_WALK_EN only)
//   walk        out  pedestrian walk lamp (registered)  (PED_WALK_EN only)
//
// Parameters: N_DIR (2..8), CNT_W, T_GREEN, T_YELLOW, T_ALLRED, T_WALK,
// all durations in ticks and >= 1.
// ---------------------------------------------------------------------------
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int N_DIR    = DEF_N_DIR,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int T_GREEN  = DEF_T_GREEN,
    parameter int T_YELLOW = DEF_T_YELLOW,
    parameter int T_ALLRED = DEF_T_ALLRED,
    parameter int T_WALK   = DEF_T_WALK
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic                       tick,
    input  logic [N_DIR-1:0]           req,
    output logic [N_DIR-1:0]           green,
    output logic [N_DIR-1:0]           yellow,
    output logic [N_DIR-1:0]           red,
    output logic [$clog2(N_DIR)-1:0]   active_dir
`ifdef PED_WALK_EN
    ,
    input  logic                       ped_req,
    output logic                       walk
`endif
);

    localparam int DIR_W = $clog2(N_DIR);

    phase_e             state_q;
    phase_e             state_d;
    logic [DIR_W-1:0]   active_dir_q;
    logic [DIR_W-1:0]   active_dir_d;
    logic [DIR_W-1:0]   next_dir_q;
    logic [DIR_W-1:0]   next_dir_d;
    logic [N_DIR-1:0]   green_q;
    logic [N_DIR-1:0]   green_d;
    logic [N_DIR-1:0]   yellow_q;
    logic [N_DIR-1:0]   yellow_d;
    logic [N_DIR-1:0]   red_q;
    logic [N_DIR-1:0]   red_d;
`ifdef PED_WALK_EN
    logic               ped_flag_q;
    logic               ped_flag_d;
    logic               walk_q;
    logic               walk_d;
`endif

    logic [CNT_W-1:0]   limit;
    logic               expired;
    logic               clear;
    int                 rr_sel;

    // Duration of the phase currently being timed.
    always_comb begin
        limit = CNT_W'(T_GREEN);
        case (state_q)
            GREEN:   limit = CNT_W'(T_GREEN);
            YELLOW:  limit = CNT_W'(T_YELLOW);
            ALLRED:  limit = CNT_W'(T_ALLRED);
            WALK:    limit = CNT_W'(T_WALK);
            default: limit = CNT_W'(T_GREEN);
        endcase
    end

    phase_timer #(
        .CNT_W   (CNT_W)
    ) u_phase_timer (
        .clock   (clock),
        .rst     (rst),
        .tick    (tick),
        .clear   (clear),
        .limit   (limit),
        .expired (expired)
    );

    // Phase sequencing. Every transition is gated by 'expired', which already
    // includes tick, so nothing moves while tick is low. Requests are only
    // looked at on the GREEN expiry tick; the chosen approach is parked in
    // next_dir and active_dir only changes when the new green starts.
    always_comb begin
        state_d      = state_q;
        active_dir_d = active_dir_q;
        next_dir_d   = next_dir_q;
        rr_sel       = rr_next_dir(8'(req), int'(active_dir_q), N_DIR);
`ifdef PED_WALK_EN
        ped_flag_d   = ped_flag_q | ped_req;
`endif
        case (state_q)
            GREEN: begin
                if (expired && (rr_sel >= 0)) begin
                    next_dir_d = DIR_W'(rr_sel);
                    state_d    = YELLOW;
                end
            end
            YELLOW: begin
                if (expired) begin
                    state_d = ALLRED;
                end
            end
            ALLRED: begin
                if (expired) begin
`ifdef PED_WALK_EN
                    // The flag is consumed as WALK starts, so a press made
                    // during the walk survives and arms the next clearance.
                    if (ped_flag_q) begin
                        state_d    = WALK;
                        ped_flag_d = ped_req;
                    end else begin
                        state_d      = GREEN;
                        active_dir_d = next_dir_q;
                    end
`else
                    state_d      = GREEN;
                    active_dir_d = next_dir_q;
`endif
                end
            end
            WALK: begin
`ifdef PED_WALK_EN
                if (expired) begin
                    state_d      = GREEN;
                    active_dir_d = next_dir_q;
                end
`else
                // Unreachable without pedestrian support; fall back safely.
                state_d      = GREEN;
                active_dir_d = next_dir_q;
`endif
            end
            default: begin
                state_d = GREEN;
            end
        endcase
    end

    // A held green keeps its saturated count; every real phase change
    // restarts the timer.
    assign clear = (state_d != state_q);

    // Lamp decode from the next state so the lamp registers change in the
    // same clock as the state register. red is the complement of the other
    // two, which keeps exactly one lamp lit per approach.
    always_comb begin
        green_d  = '0;
        yellow_d = '0;
        case (state_d)
            GREEN:   green_d  = N_DIR'(1) << active_dir_d;
            YELLOW:  yellow_d = N_DIR'(1) << active_dir_d;
            default: begin
                green_d  = '0;
                yellow_d = '0;
            end
        endcase
        red_d = ~(green_d | yellow_d);
`ifdef PED_WALK_EN
        walk_d = (state_d == WALK);
`endif
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q      <= GREEN;
            active_dir_q <= '0;
            next_dir_q   <= '0;
            green_q      <= N_DIR'(1);
            yellow_q     <= '0;
            red_q        <= ~N_DIR'(1);
`ifdef PED_WALK_EN
            ped_flag_q   <= 1'b0;
            walk_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            active_dir_q <= active_dir_d;
            next_dir_q   <= next_dir_d;
            green_q      <= green_d;
            yellow_q     <= yellow_d;
            red_q        <= red_d;
`ifdef PED_WALK_EN
            ped_flag_q   <= ped_flag_d;
            walk_q       <= walk_d;
`endif
        end
    end

    assign green      = green_q;
    assign yellow     = yellow_q;
    assign red        = red_q;
    assign active_dir = active_dir_q;
`ifdef PED_WALK_EN
    assign walk       = walk_q;
`endif

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// ---------------------------------------------------------------------------
// tb_traffic_intersection_ctrl
//
// Two controllers side by side: a default 2-approach one (20/4/2 tick
// phases) and a 4-approach one with short phases (3/2/1, walk 2) for the
// round-robin and pedestrian sequences. Expected lamp states are queued as
// each scenario is set up and compared one per clock as the DUTs run; the
// one-lamp-per-approach rule is checked on both DUTs every clock.
// ---------------------------------------------------------------------------
module tb_traffic_intersection_ctrl;

    logic       clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst2;
    logic       rst4;
    logic       tick2;
    logic       tick4;
    logic [1:0] req2;
    logic [3:0] req4;
    logic [1:0] green2;
    logic [1:0] yellow2;
    logic [1:0] red2;
    logic       active2;
    logic [3:0] green4;
    logic [3:0] yellow4;
    logic [3:0] red4;
    logic [1:0] active4;
    logic       walk2_obs;
    logic       walk4_obs;
`ifdef PED_WALK_EN
    logic       ped2;
    logic       ped4;
    logic       walk2;
    logic       walk4;
    assign walk2_obs = walk2;
    assign walk4_obs = walk4;
`else
    assign walk2_obs = 1'b0;
    assign walk4_obs = 1'b0;
`endif

    traffic_intersection_ctrl dut2 (
        .clock      (clock),
        .rst        (rst2),
        .tick       (tick2),
        .req        (req2),
        .green      (green2),
        .yellow     (yellow2),
        .red        (red2),
        .active_dir (active2)
`ifdef PED_WALK_EN
        ,
        .ped_req    (ped2),
        .walk       (walk2)
`endif
    );

    traffic_intersection_ctrl #(
        .N_DIR    (4),
        .CNT_W    (4),
        .T_GREEN  (3),
        .T_YELLOW (2),
        .T_ALLRED (1),
        .T_WALK   (2)
    ) dut4 (
        .clock      (clock),
        .rst        (rst4),
        .tick       (tick4),
        .req        (req4),
        .green      (green4),
        .yellow     (yellow4),
        .red        (red4),
        .active_dir (active4)
`ifdef PED_WALK_EN
        ,
        .ped_req    (ped4),
        .walk       (walk4)
`endif
    );

    // kind: 0 green, 1 yellow, 2 all-red, 3 walk (all-red with walk lamp)
    typedef struct {
        string      tag;
        int         unit;
        logic [3:0] g;
        logic [3:0] y;
        logic [3:0] r;
        logic [1:0] a;
        logic       w;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic exp_t make_exp(string tag, int unit, int kind, int dir);
        exp_t       e;
        logic [3:0] mask;
        mask  = (unit == 2) ? 4'b0011 : 4'b1111;
        e.tag = tag;
        e.unit = unit;
        e.g = 4'b0000;
        e.y = 4'b0000;
        e.w = 1'b0;
        if (kind == 0) e.g = 4'b0001 << dir;
        else if (kind == 1) e.y = 4'b0001 << dir;
        else if (kind == 3) e.w = 1'b1;
        e.r = mask & ~(e.g | e.y);
        e.a = 2'(dir);
        return e;
    endfunction

    task automatic push_n(string tag, int unit, int kind, int dir, int n);
        for (int i = 0; i < n; i++) exp_q.push_back(make_exp(tag, unit, kind, dir));
    endtask

    // 'pre' green samples before the expiry tick, then yellow, all-red,
    // optional walk, and the first sample of the new green.
    task automatic push_transition(string tag, int unit, int pre, int from, int to,
                                   int ny, int na, int nw);
        push_n({tag, "_green"},  unit, 0, from, pre);
        push_n({tag, "_yellow"}, unit, 1, from, ny);
        push_n({tag, "_allred"}, unit, 2, from, na);
        push_n({tag, "_walk"},   unit, 3, from, nw);
        push_n({tag, "_new"},    unit, 0, to,   1);
    endtask

    task automatic check_output();
        exp_t        e;
        logic [14:0] obs;
        logic [14:0] want;
        e = exp_q.pop_front();
        if (e.unit == 2)
            obs = {2'b00, green2, 2'b00, yellow2, 2'b00, red2, 1'b0, active2, walk2_obs};
        else
            obs = {green4, yellow4, red4, active4, walk4_obs};
        want = {e.g, e.y, e.r, e.a, e.w};
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("[TB] FAIL %s observed g/y/r/a/w=%h expected=%h", e.tag, obs, want);
        end
    endtask

    function automatic logic lamps_ok(logic [3:0] g, logic [3:0] y, logic [3:0] r, int n);
        logic ok;
        int   nonred;
        ok = 1'b1;
        nonred = 0;
        for (int i = 0; i < n; i++) begin
            if ((int'(g[i]) + int'(y[i]) + int'(r[i])) != 1) ok = 1'b0;
            if (r[i] !== 1'b1) nonred++;
        end
        if (nonred > 1) ok = 1'b0;
        return ok;
    endfunction

    task automatic check_invariants();
        logic ok2;
        logic ok4;
        ok2 = lamps_ok({2'b00, green2}, {2'b00, yellow2}, {2'b00, red2}, 2);
        ok4 = lamps_ok(green4, yellow4, red4, 4);
        checks++;
        assert (ok2 === 1'b1) else begin
            errors++;
            $error("[TB] FAIL lamp_inv2 observed g=%b y=%b r=%b expected one lamp each, one non-red",
                   green2, yellow2, red2);
        end
        checks++;
        assert (ok4 === 1'b1) else begin
            errors++;
            $error("[TB] FAIL lamp_inv4 observed g=%b y=%b r=%b expected one lamp each, one non-red",
                   green4, yellow4, red4);
        end
    endtask

    task automatic step_cycle();
        @(posedge clock);
        #1;
        check_invariants();
        if (exp_q.size() > 0) check_output();
    endtask

    task automatic drain();
        int budget;
        budget = 2000;
        while ((exp_q.size() > 0) && (budget > 0)) begin
            step_cycle();
            budget--;
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("[TB] FAIL drain_timeout observed pending=%0d expected=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst2  = 1'b0;
        rst4  = 1'b0;
        tick2 = 1'b0;
        tick4 = 1'b0;
        req2  = 2'b00;
        req4  = 4'b0000;
`ifdef PED_WALK_EN
        ped2  = 1'b0;
        ped4  = 1'b0;
`endif
        $display("[TB] start");

        // Reset state of both controllers.
        push_n("reset2", 2, 0, 0, 2);
        push_n("reset4", 4, 0, 0, 2);
        drain();
        rst2 = 1'b1;
        rst4 = 1'b1;

        // No demand: dir0 green held for 100 ticks, never yellow.
        tick2 = 1'b1;
        push_n("idle_hold", 2, 0, 0, 100);
        drain();

        // Fresh start with dir1 requesting from the first tick.
        rst2 = 1'b0;
        push_n("reset2b", 2, 0, 0, 1);
        step_cycle();
        rst2 = 1'b1;
        req2 = 2'b10;
        push_transition("main", 2, 19, 0, 1, 4, 2, 0);
        push_n("own_req_hold", 2, 0, 1, 25);
        drain();

        // Demand from dir0 with dir1's timer saturated: yellow next tick,
        // then an asynchronous reset mid-yellow.
        req2 = 2'b01;
        push_n("yellow_dir1", 2, 1, 1, 2);
        drain();
        #3;
        rst2 = 1'b0;
        #1;
        push_n("async_reset", 2, 0, 0, 1);
        check_output();
        push_n("reset_held", 2, 0, 0, 1);
        step_cycle();
        rst2 = 1'b1;

        // Freeze: 10 ticks of green, 50 clocks with tick low, then the
        // remaining 9 green ticks; req dropped during yellow is ignored.
        req2 = 2'b10;
        push_n("pre_freeze", 2, 0, 0, 10);
        drain();
        tick2 = 1'b0;
        push_n("freeze", 2, 0, 0, 50);
        drain();
        tick2 = 1'b1;
        push_transition("post_freeze", 2, 9, 0, 1, 4, 2, 0);
        for (int i = 0; i < 11; i++) step_cycle();
        req2 = 2'b00;
        drain();

        // Four approaches: reach dir2, then 1011 -> dir3, then 0011 -> wrap to dir0.
        tick4 = 1'b1;
        req4  = 4'b0100;
        push_transition("to_dir2", 4, 2, 0, 2, 2, 1, 0);
        push_n("hold_dir2", 4, 0, 2, 2);
        drain();
        req4 = 4'b1011;
        push_transition("rr_2_to_3", 4, 0, 2, 3, 2, 1, 0);
        drain();
        req4 = 4'b0011;
        push_transition("rr_wrap_3_to_0", 4, 2, 3, 0, 2, 1, 0);
        drain();

`ifdef PED_WALK_EN
        // Pedestrian press during green: walk phase after the clearance.
        ped4 = 1'b1;
        req4 = 4'b0010;
        push_transition("ped", 4, 2, 0, 1, 2, 1, 2);
        step_cycle();
        ped4 = 1'b0;
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
